// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache sitting in front of the fetch stage.
// Hits return one cycle after the request. A miss fetches the whole line from
// memory and delivers the missed word in a single response cycle.
module icache_dm #(
    parameter int LINES         = 64,
    parameter int WORDS         = 4,
    parameter int RESET_PC_LINE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        icache_ena,
    input  logic [31:0] icache_addr,
    output logic        icache_valid,
    output logic [31:0] icache_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int TW = 32 - OW - IW - 2;

    typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} state_t;

    state_t          state_q;
    logic [31:0]     dataRam [LINES*WORDS];
    logic [TW-1:0]   tagRam  [LINES];
    logic [LINES-1:0] lineValid_q;

    logic [TW-1:0]   reqTag_q;
    logic [IW-1:0]   reqIdx_q;
    logic [OW-1:0]   reqOff_q;
    logic [OW-1:0]   beatCnt_q;
    logic [OW-1:0]   beatCnt_d;
    logic            flushPend_q;
    logic            validOut_q;
    logic [31:0]     dataOut_q;
    logic            memReq_q;
    logic [31:0]     memAddr_q;

    logic [TW-1:0]   lkTag;
    logic [IW-1:0]   lkIdx;
    logic [OW-1:0]   lkOff;
    logic            lookupHit;
    logic            lastBeat;
    logic            unusedBits;

    // Byte-offset bits and the reserved preload parameter have no function in this design.
    assign unusedBits = ^{icache_addr[1:0], (RESET_PC_LINE != 0)};

    assign lkTag = icache_addr[31:OW+IW+2];
    assign lkIdx = icache_addr[OW+IW+1:OW+2];
    assign lkOff = icache_addr[OW+1:2];

    // A flush on the same edge forces the request down the miss path.
    assign lookupHit = lineValid_q[lkIdx] && (tagRam[lkIdx] == lkTag) && !flush;
    assign lastBeat  = (beatCnt_q == OW'(WORDS - 1));
    assign beatCnt_d = beatCnt_q + {{(OW-1){1'b0}}, 1'b1};

    assign icache_valid = validOut_q;
    assign icache_data  = dataOut_q;
    assign mem_req      = memReq_q;
    assign mem_addr     = memAddr_q;

    // Line storage is never reset; the valid bits alone decide whether it is usable.
    always_ff @(posedge clk) begin
        if (state_q == REFILL && mem_rvalid) begin
            dataRam[{reqIdx_q, beatCnt_q}] <= mem_rdata;
            if (lastBeat) begin
                tagRam[reqIdx_q] <= reqTag_q;
            end
        end
    end

    // Controller: lookup, memory handshake, beat collection and the response cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lineValid_q <= '0;
            reqTag_q    <= '0;
            reqIdx_q    <= '0;
            reqOff_q    <= '0;
            beatCnt_q   <= '0;
            flushPend_q <= 1'b0;
            validOut_q  <= 1'b0;
            dataOut_q   <= '0;
            memReq_q    <= 1'b0;
            memAddr_q   <= '0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    if (flush) begin
                        lineValid_q <= '0;
                    end
                    if (icache_ena) begin
                        if (lookupHit) begin
                            validOut_q <= 1'b1;
                            dataOut_q  <= dataRam[{lkIdx, lkOff}];
                            state_q    <= IDLE;
                        end else begin
                            validOut_q <= 1'b0;
                            reqTag_q   <= lkTag;
                            reqIdx_q   <= lkIdx;
                            reqOff_q   <= lkOff;
                            memReq_q   <= 1'b1;
                            memAddr_q  <= {icache_addr[31:OW+2], {(OW+2){1'b0}}};
                            state_q    <= REQ;
                        end
                    end else begin
                        // The refill response is a one-cycle pulse; a plain idle holds its word.
                        if (state_q == RESP) begin
                            validOut_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flushPend_q <= 1'b1;
                    end
                    if (mem_gnt) begin
                        memReq_q  <= 1'b0;
                        beatCnt_q <= '0;
                        state_q   <= REFILL;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flushPend_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        beatCnt_q <= beatCnt_d;
                        if (beatCnt_q == reqOff_q) begin
                            dataOut_q <= mem_rdata;
                        end
                        if (lastBeat) begin
                            if (flushPend_q || flush) begin
                                lineValid_q <= '0;
                            end else begin
                                lineValid_q[reqIdx_q] <= 1'b1;
                            end
                            flushPend_q <= 1'b0;
                            validOut_q  <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: a vector table for the cold miss and hit path,
// then hand-written sequences for eviction, handshake gaps, flush and reset.
module tb_icache_dm;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ena;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] data;
    logic        req;
    logic [31:0] maddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        ena;
        logic [31:0] addr;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        expValid;
        logic        chkData;
        logic [31:0] expData;
        logic        expReq;
        logic [31:0] expMemAddr;
    } vec_t;

    vec_t vecs [13];

    icache_dm #(.LINES(64), .WORDS(4), .RESET_PC_LINE(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .icache_ena   (ena),
        .icache_addr  (addr),
        .icache_valid (valid),
        .icache_data  (data),
        .mem_req      (req),
        .mem_addr     (maddr),
        .mem_gnt      (gnt),
        .mem_rvalid   (rvalid),
        .mem_rdata    (rdata)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic e, logic [31:0] a, logic g, logic rv, logic [31:0] rd,
                                logic ev, logic cd, logic [31:0] ed, logic er, logic [31:0] ea);
        vec_t v;
        v.ena = e; v.addr = a; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.expValid = ev; v.chkData = cd; v.expData = ed; v.expReq = er; v.expMemAddr = ea;
        return v;
    endfunction

    // One rising edge, then return at the falling edge where outputs are sampled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        ena = v.ena; addr = v.addr; gnt = v.gnt; rvalid = v.rvalid; rdata = v.rdata;
        tick();
        checkOutput($sformatf("row%0d_valid", row), {31'd0, valid}, {31'd0, v.expValid});
        checkOutput($sformatf("row%0d_req", row), {31'd0, req}, {31'd0, v.expReq});
        if (v.chkData) checkOutput($sformatf("row%0d_data", row), data, v.expData);
        if (v.expReq) checkOutput($sformatf("row%0d_memaddr", row), maddr, v.expMemAddr);
    endtask

    task automatic hitCheck(input logic [31:0] a, input logic [31:0] exp);
        ena = 1'b1; addr = a;
        tick();
        ena = 1'b0;
        checkOutput("hitValid", {31'd0, valid}, 32'd1);
        checkOutput("hitData", data, exp);
    endtask

    // Full miss: request, optional grant delay, beats per pattern (1 = beat), optional flush pulse.
    task automatic runRefill(input logic [31:0] a, input int gntDelay, input logic [15:0] pattern,
                             input int patLen, input logic [127:0] beats, input int flushStep);
        logic [31:0] expLine;
        int          off;
        int          got;
        logic        beat;
        expLine = {a[31:4], 4'h0};
        off     = int'(a[3:2]);
        got     = 0;
        ena = 1'b1; addr = a;
        tick();
        ena = 1'b0;
        checkOutput("missValid", {31'd0, valid}, 32'd0);
        checkOutput("missReq", {31'd0, req}, 32'd1);
        checkOutput("missMemAddr", maddr, expLine);
        for (int i = 0; i < gntDelay; i++) begin
            tick();
            checkOutput("reqHeld", {31'd0, req}, 32'd1);
            checkOutput("memAddrStable", maddr, expLine);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        checkOutput("gntReqDrop", {31'd0, req}, 32'd0);
        for (int s = 0; s < 40 && got < 4; s++) begin
            beat   = (s < patLen) ? pattern[s] : 1'b1;
            rvalid = beat;
            rdata  = beat ? beats[32*got +: 32] : 32'hDEAD_BEEF;
            flush  = (s == flushStep);
            tick();
            rvalid = 1'b0;
            flush  = 1'b0;
            if (beat) got++;
            if (got == 4) begin
                checkOutput("respValid", {31'd0, valid}, 32'd1);
                checkOutput("respData", data, beats[32*off +: 32]);
            end else begin
                checkOutput("noEarlyValid", {31'd0, valid}, 32'd0);
            end
        end
        checkOutput("refillBeats", got, 4);
    endtask

    localparam logic [127:0] BeatsA = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
    localparam logic [127:0] BeatsB = {32'h0000_00B3, 32'h0000_00B2, 32'h0000_00B1, 32'h0000_00B0};
    localparam logic [127:0] Beats1 = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    localparam logic [127:0] BeatsC = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};

    initial begin
        // Cold miss at 0x00400008 with grant two cycles later, then hits and a stall.
        vecs[0]  = mk(1, 32'h0040_0008, 0, 0, 0,     0, 0, 0,     1, 32'h0040_0000);
        vecs[1]  = mk(0, 32'h0040_0008, 0, 0, 0,     0, 0, 0,     1, 32'h0040_0000);
        vecs[2]  = mk(0, 32'h0040_0008, 1, 0, 0,     0, 0, 0,     0, 0);
        vecs[3]  = mk(0, 32'h0040_0008, 0, 1, 32'h11, 0, 0, 0,    0, 0);
        vecs[4]  = mk(0, 32'h0040_0008, 0, 1, 32'h22, 0, 0, 0,    0, 0);
        vecs[5]  = mk(0, 32'h0040_0008, 0, 1, 32'h33, 0, 0, 0,    0, 0);
        vecs[6]  = mk(0, 32'h0040_0008, 0, 1, 32'h44, 1, 1, 32'h33, 0, 0);
        vecs[7]  = mk(1, 32'h0040_0000, 0, 0, 0,     1, 1, 32'h11, 0, 0);
        vecs[8]  = mk(1, 32'h0040_0004, 0, 0, 0,     1, 1, 32'h22, 0, 0);
        vecs[9]  = mk(1, 32'h0040_000C, 0, 0, 0,     1, 1, 32'h44, 0, 0);
        vecs[10] = mk(0, 32'h0040_000C, 0, 0, 0,     1, 1, 32'h44, 0, 0);
        vecs[11] = mk(0, 32'h0040_000C, 0, 0, 0,     1, 1, 32'h44, 0, 0);
        vecs[12] = mk(0, 32'h0040_000C, 0, 0, 0,     1, 1, 32'h44, 0, 0);

        rst = 1'b0; flush = 1'b0; ena = 1'b0; addr = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        tick();
        checkOutput("rstValid", {31'd0, valid}, 32'd0);
        checkOutput("rstData", data, 32'd0);
        checkOutput("rstReq", {31'd0, req}, 32'd0);
        checkOutput("rstMemAddr", maddr, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);
        ena = 1'b0;

        // Conflict eviction: same index, new tag, then the old line misses again.
        runRefill(32'h0040_0400, 0, 16'hFFFF, 16, BeatsA, -1);
        runRefill(32'h0040_0000, 0, 16'hFFFF, 16, Beats1, -1);

        // Handshake stress on line 1: late grant and gapped beats, then all four words hit.
        runRefill(32'h0040_0014, 5, 16'b0000_0000_0101_1001, 7, BeatsB, -1);
        hitCheck(32'h0040_0010, 32'hB0);
        hitCheck(32'h0040_0014, 32'hB1);
        hitCheck(32'h0040_0018, 32'hB2);
        hitCheck(32'h0040_001C, 32'hB3);

        // Flush while idle: previously valid lines must miss.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        runRefill(32'h0040_0004, 0, 16'hFFFF, 16, Beats1, -1);
        runRefill(32'h0040_0014, 0, 16'hFFFF, 16, BeatsB, -1);

        // Flush mid-refill: word still delivered, immediate refetch misses, then hits.
        runRefill(32'h0040_0028, 1, 16'hFFFF, 16, Beats1, 1);
        runRefill(32'h0040_0028, 0, 16'hFFFF, 16, Beats1, -1);
        hitCheck(32'h0040_0028, 32'h33);

        // Reset after two beats of a refill on line 3.
        ena = 1'b1; addr = 32'h0040_0038;
        tick();
        ena = 1'b0;
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hC0;
        tick();
        rdata = 32'hC1;
        tick();
        rdata = 32'hEE;
        #2 rst = 1'b0;
        #1;
        checkOutput("rstMidReq", {31'd0, req}, 32'd0);
        checkOutput("rstMidValid", {31'd0, valid}, 32'd0);
        checkOutput("rstMidData", data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("strayBeatValid", {31'd0, valid}, 32'd0);
            checkOutput("strayBeatReq", {31'd0, req}, 32'd0);
        end
        rvalid = 1'b0;
        runRefill(32'h0040_0038, 0, 16'hFFFF, 16, BeatsC, -1);
        runRefill(32'h0040_0008, 0, 16'hFFFF, 16, Beats1, -1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
